two_port_alu_arbiter: RTL and testbench

TWO_PORT_ALU_ARBITER -- requirements
Module: two_port_alu_arbiter

---
 rtl/two_port_alu_arbiter.sv | 104 ++++++++++
 tb/tb_two_port_alu_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/two_port_alu_arbiter.sv
// Two-requester front end for a shared 4-bit ALU: round-robin grant,
// operand latch, result capture and a one-cycle Done pulse per operation.
module two_port_alu_arbiter (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [3:0] OpA0,
  input  logic [3:0] OpB0,
  input  logic [3:0] OpA1,
  input  logic [3:0] OpB1,
  input  logic [1:0] Ctrl0,
  input  logic [1:0] Ctrl1,
  output logic [3:0] AluOpA,
  output logic [3:0] AluOpB,
  output logic [1:0] AluCtrl,
  input  logic [3:0] AluResult,
  input  logic       AluOverflow,
  output logic [3:0] Result,
  output logic       Overflow,
  output logic       Done0,
  output logic       Done1,
  output logic       Grant,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITEBACK} state_t;

  state_t     state, state_next;
  logic       last, last_next;
  logic       grant_next, pick;
  logic [3:0] op_a_next, op_b_next, result_next;
  logic [1:0] ctrl_next;
  logic       overflow_next, done0_next, done1_next;

  assign Busy = (state != IDLE);

  // On a tie the requester that did not go last wins.
  assign pick = (Req0 && Req1) ? ~last : Req1;

  always_comb begin
    state_next    = state;
    last_next     = last;
    grant_next    = Grant;
    op_a_next     = AluOpA;
    op_b_next     = AluOpB;
    ctrl_next     = AluCtrl;
    result_next   = Result;
    overflow_next = Overflow;
    done0_next    = 1'b0;
    done1_next    = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          grant_next = pick;
          op_a_next  = pick ? OpA1  : OpA0;
          op_b_next  = pick ? OpB1  : OpB0;
          ctrl_next  = pick ? Ctrl1 : Ctrl0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        result_next   = AluResult;
        overflow_next = AluOverflow;
        state_next    = WRITEBACK;
      end
      WRITEBACK: begin
        // Done is registered, so the pulse lands in the first IDLE cycle.
        done0_next = ~Grant;
        done1_next = Grant;
        last_next  = Grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      Grant    <= 1'b0;
      AluOpA   <= '0;
      AluOpB   <= '0;
      AluCtrl  <= '0;
      Result   <= '0;
      Overflow <= 1'b0;
      Done0    <= 1'b0;
      Done1    <= 1'b0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      Grant    <= grant_next;
      AluOpA   <= op_a_next;
      AluOpB   <= op_b_next;
      AluCtrl  <= ctrl_next;
      Result   <= result_next;
      Overflow <= overflow_next;
      Done0    <= done0_next;
      Done1    <= done1_next;
    end
  end

endmodule

// File: tb/tb_two_port_alu_arbiter.sv
// Scoreboard bench for two_port_alu_arbiter with an adder/overflow ALU model.
module tb_two_port_alu_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Req0, Req1;
  logic [3:0] OpA0, OpB0, OpA1, OpB1;
  logic [1:0] Ctrl0, Ctrl1;
  logic [3:0] AluOpA, AluOpB, AluResult, Result;
  logic [1:0] AluCtrl;
  logic       AluOverflow, Overflow, Done0, Done1, Grant, Busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic       grant;
    logic [3:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  two_port_alu_arbiter dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .OpA0(OpA0), .OpB0(OpB0), .OpA1(OpA1), .OpB1(OpB1),
    .Ctrl0(Ctrl0), .Ctrl1(Ctrl1),
    .AluOpA(AluOpA), .AluOpB(AluOpB), .AluCtrl(AluCtrl),
    .AluResult(AluResult), .AluOverflow(AluOverflow),
    .Result(Result), .Overflow(Overflow),
    .Done0(Done0), .Done1(Done1), .Grant(Grant), .Busy(Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign AluResult   = AluOpA + AluOpB;
  assign AluOverflow = (AluOpA[3] == AluOpB[3]) && (AluResult[3] != AluOpA[3]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected values computed from the operands the bench drove.
  task automatic push_exp(input logic g, input logic [3:0] a, input logic [3:0] b, input int done_cyc);
    exp_t e;
    logic [3:0] s;
    s = a + b;
    e.grant = g;
    e.res   = s;
    e.ovf   = (a[3] == b[3]) && (s[3] != a[3]);
    e.cyc   = done_cyc;
    sb.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (Done0 || Done1) begin
      check("done_excl", {31'd0, Done0 & Done1}, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_sel", {30'd0, Done1, Done0}, e.grant ? 2 : 1);
        check("grant", {31'd0, Grant}, {31'd0, e.grant});
        check("result", {28'd0, Result}, {28'd0, e.res});
        check("overflow", {31'd0, Overflow}, {31'd0, e.ovf});
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge Clk); #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; Req0 = 0; Req1 = 0;
    OpA0 = '0; OpB0 = '0; OpA1 = '0; OpB1 = '0; Ctrl0 = '0; Ctrl1 = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("reset_outs", {14'd0, AluOpA, AluOpB, AluCtrl, Result, Overflow, Done0, Done1, Grant, Busy}, 0);
    end

    // Single request on port 0
    Req0 = 1; OpA0 = 4'h3; OpB0 = 4'h2; Ctrl0 = 2'b01;
    push_exp(0, 4'h3, 4'h2, cyc + 3);
    @(negedge Clk);
    check("busy_after_grant", {31'd0, Busy}, 1);
    check("latched_a", {28'd0, AluOpA}, 3);
    check("latched_ctrl", {30'd0, AluCtrl}, 1);
    wait_done(8);
    Req0 = 0;
    repeat (3) @(negedge Clk);
    check("hold_outs", {20'd0, AluOpA, AluOpB, Result, Grant, Busy, Done0, Done1}, {20'd0, 4'h3, 4'h2, 4'h5, 4'b0000});

    // Single request on port 1, signed overflow
    Req1 = 1; OpA1 = 4'h7; OpB1 = 4'h1; Ctrl1 = 2'b10;
    push_exp(1, 4'h7, 4'h1, cyc + 3);
    @(negedge Clk);
    check("latched_ctrl1", {30'd0, AluCtrl}, 2);
    wait_done(8);
    Req1 = 0;
    repeat (2) @(negedge Clk);

    // Both held from reset: round robin 0,1,0,1
    Rst = 1;
    @(negedge Clk);
    Rst = 0; Req0 = 1; Req1 = 1;
    OpA0 = 4'h1; OpB0 = 4'h2; OpA1 = 4'h6; OpB1 = 4'h5;
    push_exp(0, 4'h1, 4'h2, cyc + 3);
    push_exp(1, 4'h6, 4'h5, cyc + 6);
    push_exp(0, 4'h1, 4'h2, cyc + 9);
    push_exp(1, 4'h6, 4'h5, cyc + 12);
    wait_done(20);
    Req0 = 0; Req1 = 0;
    repeat (3) @(negedge Clk);
    check("idle_after_rr", {31'd0, Busy}, 0);

    // Operand change after grant must not disturb the operation
    Req0 = 1; OpA0 = 4'h3; OpB0 = 4'h2;
    push_exp(0, 4'h3, 4'h2, cyc + 3);
    @(negedge Clk);
    OpA0 = 4'hF; Req0 = 0;
    wait_done(8);
    check("latched_a_stable", {28'd0, AluOpA}, 3);
    repeat (2) @(negedge Clk);

    // Reset during WRITEBACK aborts: no Done, Result cleared
    Req0 = 1; OpA0 = 4'h4; OpB0 = 4'h4;
    @(negedge Clk);
    Req0 = 0;
    @(negedge Clk);
    check("busy_in_wb", {31'd0, Busy}, 1);
    Rst = 1;
    @(negedge Clk);
    Rst = 0;
    check("abort_outs", {24'd0, Result, Busy, Done0, Done1, Overflow}, 0);
    repeat (4) @(negedge Clk);
    check("abort_idle", {28'd0, Busy, Done0, Done1, Overflow}, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
